// File: rtl/eth_parser_pkg.sv
// rtl/eth_parser_pkg.sv - header metadata type, constants and helpers for eth_frame_parser_wide
// ETH_PARSER_VLAN_EN widens the captured header window to hold one 802.1Q tag.
package eth_parser_pkg;

   localparam int          ETH_HDR_LEN      = 14;
   localparam int          ETH_VLAN_HDR_LEN = 18;
   localparam logic [15:0] ETHERTYPE_VLAN   = 16'h8100;

`ifdef ETH_PARSER_VLAN_EN
   localparam int HDR_CAP_BYTES = ETH_VLAN_HDR_LEN;
`else
   localparam int HDR_CAP_BYTES = ETH_HDR_LEN;
`endif

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [47:0] src_mac;
      logic [15:0] ethertype;
      logic        vlan_valid;
      logic [15:0] vlan_tci;
      logic        runt;
      logic [15:0] byte_count;
   } eth_hdr_meta_t;

   typedef enum logic {ST_HDR, ST_BODY} parse_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/eth_hdr_capture.sv
// rtl/eth_hdr_capture.sv - per-lane offset compare writing frame header bytes into capture registers
// hdr_next is the header image including the current beat, so the tlast beat can report it directly.
module eth_hdr_capture
   import eth_parser_pkg::*;
#(
   parameter int DATA_BYTES = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        capture_en,
   input  logic                        clear,
   input  logic [7:0]                  off,
   input  logic [8*DATA_BYTES-1:0]     tdata,
   input  logic [DATA_BYTES-1:0]       tkeep,
   output logic [8*HDR_CAP_BYTES-1:0]  hdr_next
);

   logic [8*HDR_CAP_BYTES-1:0] hdr_q;

   always_comb begin
      hdr_next = hdr_q;
      if (capture_en) begin
         for (int l = 0; l < DATA_BYTES; l++) begin
            for (int k = 0; k < HDR_CAP_BYTES; k++) begin
               if (tkeep[l] && (int'(off) + l == k)) hdr_next[k*8 +: 8] = tdata[l*8 +: 8];
            end
         end
      end
   end

   // Clear wins so a frame never inherits header bytes from its predecessor.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          hdr_q <= '0;
      else if (clear)      hdr_q <= '0;
      else if (capture_en) hdr_q <= hdr_next;
   end

endmodule

// File: rtl/eth_frame_parser_wide.sv
// rtl/eth_frame_parser_wide.sv - one-stage pass-through stream with Ethernet header metadata extraction
// Define ETH_PARSER_VLAN_EN to decode a single 802.1Q tag.
module eth_frame_parser_wide
   import eth_parser_pkg::*;
#(
   parameter int DATA_BYTES = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [8*DATA_BYTES-1:0]  s_axis_tdata,
   input  logic [DATA_BYTES-1:0]    s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic                     s_axis_tlast,
   output logic [8*DATA_BYTES-1:0]  m_axis_tdata,
   output logic [DATA_BYTES-1:0]    m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output eth_hdr_meta_t            m_axis_tuser,
   output logic                     m_axis_tuser_valid
);

   parse_state_t               state;
   logic [7:0]                 off;
   logic [15:0]                byte_count;
   logic                       ready_en;
   logic                       accept;
   logic [3:0]                 beat_bytes;
   logic [8:0]                 off_sum;
   logic [16:0]                bc_sum;
   logic [15:0]                bc_next;
   logic [8*HDR_CAP_BYTES-1:0] hdr_next;
   logic [7:0]                 hb [HDR_CAP_BYTES];
   logic [7:0]                 hdr_len;
   logic                       vlan_tag;
   eth_hdr_meta_t              meta_next;

   // ready_en holds tready low while in reset and for the first cycle out of it.
   assign s_axis_tready      = ready_en && (!m_axis_tvalid || m_axis_tready);
   assign accept             = s_axis_tvalid && s_axis_tready;
   assign m_axis_tuser_valid = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   assign beat_bytes = popcount8(8'(s_axis_tkeep));
   assign off_sum    = 9'(off) + 9'(beat_bytes);
   assign bc_sum     = {1'b0, byte_count} + 17'(beat_bytes);
   assign bc_next    = bc_sum[16] ? 16'hFFFF : bc_sum[15:0];

   eth_hdr_capture #(.DATA_BYTES(DATA_BYTES)) u_capture (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture_en (accept && (state == ST_HDR)),
      .clear      (accept && s_axis_tlast),
      .off        (off),
      .tdata      (s_axis_tdata),
      .tkeep      (s_axis_tkeep),
      .hdr_next   (hdr_next)
   );

   always_comb begin
      for (int k = 0; k < HDR_CAP_BYTES; k++) hb[k] = hdr_next[k*8 +: 8];
   end

   always_comb begin
      meta_next = '0;
      vlan_tag  = 1'b0;
`ifdef ETH_PARSER_VLAN_EN
      vlan_tag  = ({hb[12], hb[13]} == ETHERTYPE_VLAN);
`endif
      hdr_len              = vlan_tag ? 8'(ETH_VLAN_HDR_LEN) : 8'(ETH_HDR_LEN);
      meta_next.dst_mac    = {hb[0], hb[1], hb[2], hb[3], hb[4], hb[5]};
      meta_next.src_mac    = {hb[6], hb[7], hb[8], hb[9], hb[10], hb[11]};
      meta_next.ethertype  = {hb[12], hb[13]};
`ifdef ETH_PARSER_VLAN_EN
      if (vlan_tag) begin
         meta_next.vlan_valid = 1'b1;
         meta_next.vlan_tci   = {hb[14], hb[15]};
         meta_next.ethertype  = {hb[16], hb[17]};
      end
`endif
      // In BODY off is frozen at or past hdr_len, so runt can only fire from HDR.
      meta_next.runt       = (off_sum < 9'(hdr_len));
      meta_next.byte_count = bc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_HDR;
         off           <= '0;
         byte_count    <= '0;
         ready_en      <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
      end else begin
         ready_en <= 1'b1;
         if (accept) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tkeep  <= s_axis_tkeep;
            m_axis_tlast  <= s_axis_tlast;
            m_axis_tvalid <= 1'b1;
            if (s_axis_tlast) begin
               state        <= ST_HDR;
               off          <= '0;
               byte_count   <= '0;
               m_axis_tuser <= meta_next;
            end else begin
               byte_count <= bc_next;
               if (state == ST_HDR) begin
                  off <= off_sum[7:0];
                  if (off_sum >= 9'(hdr_len)) state <= ST_BODY;
               end
            end
         end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_eth_frame_parser_wide.sv
// tb/tb_eth_frame_parser_wide.sv - directed self-checking bench for eth_frame_parser_wide
// Three instances (8, 1 and 4 byte lanes); VLAN expectations follow ETH_PARSER_VLAN_EN.
module tb_eth_frame_parser_wide;
   import eth_parser_pkg::*;

   logic clk, rst_n;
   int   tests, fails;

   logic [63:0] a_tdata, am_tdata;
   logic [7:0]  a_tkeep, am_tkeep;
   logic        a_tvalid, a_tready, a_tlast, am_tvalid, am_tready, am_tlast, a_tuser_valid;
   eth_hdr_meta_t a_tuser;

   logic [7:0]  b_tdata, bm_tdata;
   logic [0:0]  b_tkeep, bm_tkeep;
   logic        b_tvalid, b_tready, b_tlast, bm_tvalid, bm_tready, bm_tlast, b_tuser_valid;
   eth_hdr_meta_t b_tuser;

   logic [31:0] c_tdata, cm_tdata;
   logic [3:0]  c_tkeep, cm_tkeep;
   logic        c_tvalid, c_tready, c_tlast, cm_tvalid, cm_tready, cm_tlast, c_tuser_valid;
   eth_hdr_meta_t c_tuser;

   logic        a_bp;
   logic [7:0]  frame[$], a_exp[$], a_rx[$], b_rx[$], c_rx[$];
   eth_hdr_meta_t a_meta[$], b_meta[$], c_meta[$], exp_m[$];
   logic [7:0]  a_last_keep;
   int          a_unstable;
   logic        a_hold, a_hold_last;
   logic [63:0] a_hold_data;
   logic [7:0]  a_hold_keep;

   eth_frame_parser_wide #(.DATA_BYTES(8)) u_a (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(a_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tvalid(a_tvalid),
      .s_axis_tready(a_tready), .s_axis_tlast(a_tlast),
      .m_axis_tdata(am_tdata), .m_axis_tkeep(am_tkeep), .m_axis_tvalid(am_tvalid),
      .m_axis_tready(am_tready), .m_axis_tlast(am_tlast),
      .m_axis_tuser(a_tuser), .m_axis_tuser_valid(a_tuser_valid));

   eth_frame_parser_wide #(.DATA_BYTES(1)) u_b (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tvalid(b_tvalid),
      .s_axis_tready(b_tready), .s_axis_tlast(b_tlast),
      .m_axis_tdata(bm_tdata), .m_axis_tkeep(bm_tkeep), .m_axis_tvalid(bm_tvalid),
      .m_axis_tready(bm_tready), .m_axis_tlast(bm_tlast),
      .m_axis_tuser(b_tuser), .m_axis_tuser_valid(b_tuser_valid));

   eth_frame_parser_wide #(.DATA_BYTES(4)) u_c (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(c_tdata), .s_axis_tkeep(c_tkeep), .s_axis_tvalid(c_tvalid),
      .s_axis_tready(c_tready), .s_axis_tlast(c_tlast),
      .m_axis_tdata(cm_tdata), .m_axis_tkeep(cm_tkeep), .m_axis_tvalid(cm_tvalid),
      .m_axis_tready(cm_tready), .m_axis_tlast(cm_tlast),
      .m_axis_tuser(c_tuser), .m_axis_tuser_valid(c_tuser_valid));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      am_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         am_tready = a_bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Monitors sample at negedge: a valid&&ready seen here completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && a_hold && (am_tvalid !== 1'b1 || am_tdata !== a_hold_data ||
                              am_tkeep !== a_hold_keep || am_tlast !== a_hold_last))
         a_unstable++;
      a_hold      = rst_n && am_tvalid && !am_tready;
      a_hold_data = am_tdata;
      a_hold_keep = am_tkeep;
      a_hold_last = am_tlast;
      if (am_tvalid && am_tready) begin
         for (int i = 0; i < 8; i++) if (am_tkeep[i]) a_rx.push_back(am_tdata[i*8 +: 8]);
         if (am_tlast) a_last_keep = am_tkeep;
      end
      if (a_tuser_valid) a_meta.push_back(a_tuser);
   end

   always @(negedge clk) begin
      if (bm_tvalid && bm_tready && bm_tkeep[0]) b_rx.push_back(bm_tdata);
      if (b_tuser_valid) b_meta.push_back(b_tuser);
   end

   always @(negedge clk) begin
      if (cm_tvalid && cm_tready)
         for (int i = 0; i < 4; i++) if (cm_tkeep[i]) c_rx.push_back(cm_tdata[i*8 +: 8]);
      if (c_tuser_valid) c_meta.push_back(c_tuser);
   end

   task automatic make_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] et);
      logic [111:0] h;
      h = {dst, src, et};
      frame.delete();
      for (int i = 0; i < len; i++) frame.push_back((i < 14) ? h[111 - i*8 -: 8] : 8'($urandom));
   endtask

   function automatic eth_hdr_meta_t exp_meta(input int len);
      eth_hdr_meta_t m;
      logic [7:0] b [18];
      for (int i = 0; i < 18; i++) b[i] = (i < len) ? frame[i] : 8'h00;
      m = '0;
      m.dst_mac   = {b[0], b[1], b[2], b[3], b[4], b[5]};
      m.src_mac   = {b[6], b[7], b[8], b[9], b[10], b[11]};
      m.ethertype = {b[12], b[13]};
      m.runt      = (len < 14);
`ifdef ETH_PARSER_VLAN_EN
      if ({b[12], b[13]} == 16'h8100) begin
         m.vlan_valid = 1'b1;
         m.vlan_tci   = {b[14], b[15]};
         m.ethertype  = {b[16], b[17]};
         m.runt       = (len < 18);
      end
`endif
      m.byte_count = (len > 65535) ? 16'hFFFF : 16'(len);
      return m;
   endfunction

   // Sends frame bytes [0, limit) on instance 0/1/2; tlast only on the frame's real last beat.
   task automatic send_frame(input int which, input int limit);
      int lanes, n;
      logic [63:0] d;
      logic [7:0]  k;
      logic        l, rdy;
      lanes = (which == 0) ? 8 : ((which == 1) ? 1 : 4);
      for (int i = 0; i < limit; i += lanes) begin
         d = '0;
         k = '0;
         for (int j = 0; j < lanes; j++)
            if (i + j < frame.size()) begin
               d[j*8 +: 8] = frame[i+j];
               k[j] = 1'b1;
            end
         l = (i + lanes >= frame.size());
         case (which)
            0:       begin a_tdata = d;       a_tkeep = k;      a_tlast = l; a_tvalid = 1'b1; end
            1:       begin b_tdata = d[7:0];  b_tkeep = k[0:0]; b_tlast = l; b_tvalid = 1'b1; end
            default: begin c_tdata = d[31:0]; c_tkeep = k[3:0]; c_tlast = l; c_tvalid = 1'b1; end
         endcase
         n = 0;
         @(negedge clk);
         rdy = (which == 0) ? a_tready : ((which == 1) ? b_tready : c_tready);
         while (!rdy) begin
            n++;
            if (n > 2000) begin
               $display("FAIL send_stall: s_axis_tready stayed 0 for %0d cycles, required 1", n);
               $fatal(1, "input stalled");
            end
            @(negedge clk);
            rdy = (which == 0) ? a_tready : ((which == 1) ? b_tready : c_tready);
         end
         @(posedge clk); #1;
         a_tvalid = 1'b0;
         b_tvalid = 1'b0;
         c_tvalid = 1'b0;
      end
   endtask

   task automatic wait_meta(input int which, input int n);
      int t, sz;
      t = 0;
      sz = (which == 0) ? a_meta.size() : ((which == 1) ? b_meta.size() : c_meta.size());
      while (sz < n && t < 5000) begin
         @(posedge clk); #1;
         t++;
         sz = (which == 0) ? a_meta.size() : ((which == 1) ? b_meta.size() : c_meta.size());
      end
      repeat (4) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      @(negedge clk);
      tests++; if (a_tready !== 1'b0) begin fails++; $display("FAIL rst_tready: got %b want 0", a_tready); end
      tests++; if (am_tvalid !== 1'b0) begin fails++; $display("FAIL rst_tvalid: got %b want 0", am_tvalid); end
      tests++; if (am_tlast !== 1'b0) begin fails++; $display("FAIL rst_tlast: got %b want 0", am_tlast); end
      tests++; if (am_tkeep !== 8'h00) begin fails++; $display("FAIL rst_tkeep: got %h want 00", am_tkeep); end
      tests++; if (am_tdata !== 64'h0) begin fails++; $display("FAIL rst_tdata: got %h want 0", am_tdata); end
      tests++; if (a_tuser !== '0) begin fails++; $display("FAIL rst_tuser: got %h want 0", a_tuser); end
      tests++; if (a_tuser_valid !== 1'b0) begin fails++; $display("FAIL rst_tuser_valid: got %b want 0", a_tuser_valid); end
      tests++;
      if ({b_tready, bm_tvalid, c_tready, cm_tvalid, bm_tdata, cm_tdata} !== '0) begin
         fails++; $display("FAIL rst_bc: b/c outputs got %b%b%b%b want 0000", b_tready, bm_tvalid, c_tready, cm_tvalid);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      tests++; if (a_tready !== 1'b1) begin fails++; $display("FAIL post_rst_tready: got %b want 1", a_tready); end
      @(posedge clk); #1;
   endtask

   task automatic test_db1_ipv4();
      eth_hdr_meta_t m;
      int bad;
      b_rx.delete(); b_meta.delete();
      make_frame(64, 48'h00_11_22_33_44_55, 48'h66_77_88_99_AA_BB, 16'h0800);
      send_frame(1, frame.size());
      wait_meta(1, 1);
      m = (b_meta.size() > 0) ? b_meta[0] : '0;
      bad = -1;
      for (int i = 0; i < b_rx.size() && i < frame.size(); i++) if (b_rx[i] !== frame[i] && bad < 0) bad = i;
      tests++;
      if (b_rx.size() != 64 || bad >= 0) begin
         fails++; $display("FAIL db1_data: got %0d bytes (first bad %0d) want 64 identical", b_rx.size(), bad);
      end
      tests++; if (b_meta.size() != 1) begin fails++; $display("FAIL db1_strobes: got %0d want 1", b_meta.size()); end
      tests++; if (m.ethertype !== 16'h0800) begin fails++; $display("FAIL db1_ethertype: got %h want 0800", m.ethertype); end
      tests++; if (m.byte_count !== 16'd64) begin fails++; $display("FAIL db1_byte_count: got %0d want 64", m.byte_count); end
      tests++; if (m.runt !== 1'b0) begin fails++; $display("FAIL db1_runt: got %b want 0", m.runt); end
      tests++; if (m.dst_mac !== 48'h001122334455) begin fails++; $display("FAIL db1_dst: got %h want 001122334455", m.dst_mac); end
      tests++; if (m.src_mac !== 48'h66778899AABB) begin fails++; $display("FAIL db1_src: got %h want 66778899aabb", m.src_mac); end
   endtask

   task automatic test_db8_odd_len();
      eth_hdr_meta_t m;
      int bad;
      a_rx.delete(); a_meta.delete(); a_unstable = 0;
      a_bp = 1'b1;
      make_frame(61, 48'h02_00_00_00_00_01, 48'h02_00_00_00_00_02, 16'h0800);
      send_frame(0, frame.size());
      wait_meta(0, 1);
      a_bp = 1'b0;
      m = (a_meta.size() > 0) ? a_meta[0] : '0;
      bad = -1;
      for (int i = 0; i < a_rx.size() && i < frame.size(); i++) if (a_rx[i] !== frame[i] && bad < 0) bad = i;
      tests++;
      if (a_rx.size() != 61 || bad >= 0) begin
         fails++; $display("FAIL db8_data: got %0d bytes (first bad %0d) want 61 identical", a_rx.size(), bad);
      end
      tests++; if (a_last_keep !== 8'h1F) begin fails++; $display("FAIL db8_last_keep: got %h want 1f", a_last_keep); end
      tests++; if (a_meta.size() != 1) begin fails++; $display("FAIL db8_strobes: got %0d want 1", a_meta.size()); end
      tests++; if (m.byte_count !== 16'd61) begin fails++; $display("FAIL db8_byte_count: got %0d want 61", m.byte_count); end
      tests++; if (m.runt !== 1'b0) begin fails++; $display("FAIL db8_runt: got %b want 0", m.runt); end
      tests++; if (a_unstable != 0) begin fails++; $display("FAIL db8_hold: %0d unstable stalled beats, want 0", a_unstable); end
   endtask

   task automatic test_db4_runt();
      eth_hdr_meta_t m;
      c_rx.delete(); c_meta.delete();
      frame.delete();
      for (int i = 0; i < 10; i++) frame.push_back(8'h10 + 8'(i));
      send_frame(2, frame.size());
      wait_meta(2, 1);
      m = (c_meta.size() > 0) ? c_meta[0] : '0;
      tests++; if (c_meta.size() != 1) begin fails++; $display("FAIL runt_strobes: got %0d want 1", c_meta.size()); end
      tests++; if (m.runt !== 1'b1) begin fails++; $display("FAIL runt_flag: got %b want 1", m.runt); end
      tests++; if (m.dst_mac !== 48'h101112131415) begin fails++; $display("FAIL runt_dst: got %h want 101112131415", m.dst_mac); end
      tests++; if (m.src_mac !== 48'h161718190000) begin fails++; $display("FAIL runt_src: got %h want 161718190000", m.src_mac); end
      tests++; if (m.ethertype !== 16'h0000) begin fails++; $display("FAIL runt_ethertype: got %h want 0000", m.ethertype); end
      tests++; if (m.byte_count !== 16'd10) begin fails++; $display("FAIL runt_byte_count: got %0d want 10", m.byte_count); end
      tests++; if (c_rx.size() != 10) begin fails++; $display("FAIL runt_data: got %0d bytes want 10", c_rx.size()); end
   endtask

   task automatic test_single_beat();
      eth_hdr_meta_t m;
      a_rx.delete(); a_meta.delete();
      frame.delete();
      for (int i = 0; i < 8; i++) frame.push_back(8'hA0 + 8'(i));
      send_frame(0, frame.size());
      wait_meta(0, 1);
      m = (a_meta.size() > 0) ? a_meta[0] : '0;
      tests++; if (a_meta.size() != 1) begin fails++; $display("FAIL single_strobes: got %0d want 1", a_meta.size()); end
      tests++; if (m.runt !== 1'b1) begin fails++; $display("FAIL single_runt: got %b want 1", m.runt); end
      tests++; if (m.byte_count !== 16'd8) begin fails++; $display("FAIL single_byte_count: got %0d want 8", m.byte_count); end
      tests++; if (m.src_mac !== 48'hA6A700000000) begin fails++; $display("FAIL single_src: got %h want a6a700000000", m.src_mac); end
   endtask

   task automatic test_vlan();
      eth_hdr_meta_t m;
      a_meta.delete();
      make_frame(64, 48'h0A_0B_0C_0D_0E_0F, 48'h1A_1B_1C_1D_1E_1F, 16'h8100);
      frame[14] = 8'hA0; frame[15] = 8'h05; frame[16] = 8'h86; frame[17] = 8'hDD;
      send_frame(0, frame.size());
      wait_meta(0, 1);
      m = (a_meta.size() > 0) ? a_meta[0] : '0;
      tests++; if (a_meta.size() != 1) begin fails++; $display("FAIL vlan_strobes: got %0d want 1", a_meta.size()); end
`ifdef ETH_PARSER_VLAN_EN
      tests++; if (m.vlan_valid !== 1'b1) begin fails++; $display("FAIL vlan_valid: got %b want 1", m.vlan_valid); end
      tests++; if (m.vlan_tci !== 16'hA005) begin fails++; $display("FAIL vlan_tci: got %h want a005", m.vlan_tci); end
      tests++; if (m.ethertype !== 16'h86DD) begin fails++; $display("FAIL vlan_ethertype: got %h want 86dd", m.ethertype); end
`else
      tests++; if (m.vlan_valid !== 1'b0) begin fails++; $display("FAIL vlan_valid: got %b want 0", m.vlan_valid); end
      tests++; if (m.vlan_tci !== 16'h0000) begin fails++; $display("FAIL vlan_tci: got %h want 0000", m.vlan_tci); end
      tests++; if (m.ethertype !== 16'h8100) begin fails++; $display("FAIL vlan_ethertype: got %h want 8100", m.ethertype); end
`endif
      tests++; if (m.runt !== 1'b0) begin fails++; $display("FAIL vlan_runt: got %b want 0", m.runt); end
   endtask

   task automatic test_back_to_back();
      int len, bad;
      a_rx.delete(); a_meta.delete(); a_exp.delete(); exp_m.delete(); a_unstable = 0;
      a_bp = 1'b1;
      for (int f = 0; f < 50; f++) begin
         len = int'($urandom_range(64, 256));
         make_frame(len, {16'h0200, 32'($urandom)}, {16'h0400, 32'($urandom)}, {8'h08, 8'($urandom)});
         foreach (frame[i]) a_exp.push_back(frame[i]);
         exp_m.push_back(exp_meta(len));
         send_frame(0, frame.size());
      end
      wait_meta(0, 50);
      a_bp = 1'b0;
      bad = -1;
      for (int i = 0; i < a_rx.size() && i < a_exp.size(); i++) if (a_rx[i] !== a_exp[i] && bad < 0) bad = i;
      tests++;
      if (a_rx.size() != a_exp.size() || bad >= 0) begin
         fails++; $display("FAIL b2b_data: got %0d bytes (first bad %0d) want %0d identical", a_rx.size(), bad, a_exp.size());
      end
      tests++; if (a_meta.size() != 50) begin fails++; $display("FAIL b2b_strobes: got %0d want 50", a_meta.size()); end
      tests++; if (a_unstable != 0) begin fails++; $display("FAIL b2b_hold: %0d unstable stalled beats, want 0", a_unstable); end
      for (int f = 0; f < a_meta.size() && f < 50; f++) begin
         tests++;
         if (a_meta[f] !== exp_m[f]) begin
            fails++; $display("FAIL b2b_meta%0d: got %h want %h", f, a_meta[f], exp_m[f]);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      eth_hdr_meta_t m;
      int bad;
      a_meta.delete();
      make_frame(64, 48'hDE_AD_00_00_00_01, 48'hDE_AD_00_00_00_02, 16'h0800);
      send_frame(0, 24);
      rst_n = 1'b0;
      @(negedge clk);
      tests++; if (am_tvalid !== 1'b0) begin fails++; $display("FAIL mid_rst_tvalid: got %b want 0", am_tvalid); end
      tests++; if (a_tuser !== '0) begin fails++; $display("FAIL mid_rst_tuser: got %h want 0", a_tuser); end
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      tests++; if (a_meta.size() != 0) begin fails++; $display("FAIL mid_abort_strobe: got %0d want 0", a_meta.size()); end
      a_rx.delete();
      make_frame(64, 48'h00_AA_BB_CC_DD_EE, 48'h00_12_34_56_78_9A, 16'h0806);
      send_frame(0, frame.size());
      wait_meta(0, 1);
      m = (a_meta.size() > 0) ? a_meta[0] : '0;
      tests++; if (a_meta.size() != 1) begin fails++; $display("FAIL mid_strobes: got %0d want 1", a_meta.size()); end
      tests++; if (m !== exp_meta(64)) begin fails++; $display("FAIL mid_meta: got %h want %h", m, exp_meta(64)); end
      bad = -1;
      for (int i = 0; i < a_rx.size() && i < frame.size(); i++) if (a_rx[i] !== frame[i] && bad < 0) bad = i;
      tests++;
      if (a_rx.size() != 64 || bad >= 0) begin
         fails++; $display("FAIL mid_data: got %0d bytes (first bad %0d) want 64 identical", a_rx.size(), bad);
      end
   endtask

   initial begin
      tests = 0; fails = 0; a_unstable = 0; a_bp = 1'b0; a_hold = 1'b0; a_last_keep = '0;
      rst_n = 1'b0;
      a_tdata = '0; a_tkeep = '0; a_tvalid = 1'b0; a_tlast = 1'b0;
      b_tdata = '0; b_tkeep = '0; b_tvalid = 1'b0; b_tlast = 1'b0; bm_tready = 1'b1;
      c_tdata = '0; c_tkeep = '0; c_tvalid = 1'b0; c_tlast = 1'b0; cm_tready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      test_reset();
      test_db1_ipv4();
      test_db8_odd_len();
      test_db4_runt();
      test_single_beat();
      test_vlan();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
